// File: rtl/mmu_pkg.sv
// Shared types and helpers for the segmented MMU: region decode and byte merge.
package mmu_pkg;

    // Widest word/address the helpers operate on; callers zero-extend into it.
    localparam int unsigned MAX_W      = 64;
    localparam int unsigned MAX_STRB_W = MAX_W / 8;

    typedef enum logic [1:0] {
        REG_NULL,
        REG_SPECIAL,
        REG_MEM,
        REG_INVALID
    } region_e;

    typedef enum logic {
        IDLE,
        BUSY
    } port_state_e;

    // Classify a word address into one of the four map regions (full-width compare).
    function automatic region_e mmu_region(
        input logic [MAX_W-1:0] addr,
        input logic [MAX_W-1:0] special_words,
        input logic [MAX_W-1:0] mem_base,
        input logic [MAX_W-1:0] mem_words
    );
        if (addr == '0)
            return REG_NULL;
        else if (addr <= special_words)
            return REG_SPECIAL;
        else if ((addr >= mem_base) && ((addr - mem_base) < mem_words))
            return REG_MEM;
        else
            return REG_INVALID;
    endfunction

    // Array index inside the decoded region; zero for regions without storage.
    function automatic logic [MAX_W-1:0] mmu_index(
        input logic [MAX_W-1:0] addr,
        input region_e          region,
        input logic [MAX_W-1:0] mem_base
    );
        case (region)
            REG_SPECIAL: return addr - MAX_W'(1);
            REG_MEM:     return addr - mem_base;
            default:     return '0;
        endcase
    endfunction

    // Replace the bytes of old_w selected by strb with the matching bytes of new_w.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]      old_w,
        input logic [MAX_W-1:0]      new_w,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int b = 0; b < int'(MAX_STRB_W); b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmu_port_ctrl.sv
// Per-port handshake: accepts a request when idle (or on the completing edge),
// counts LATENCY cycles, raises wait meanwhile and strobes valid on completion.
module mmu_port_ctrl
    import mmu_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic accept_c_o,
    output logic done_c_o,
    output logic wait_o,
    output logic valid_o
);

    localparam int unsigned    CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    port_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wait_q;
    logic             valid_q;
    logic             done_c;
    logic             accept_c;

    // Completion happens on the edge where the counter reaches its last value.
    assign done_c   = (state_q == BUSY) && (cnt_q == CNT_LAST);
    // A completing port can take the next request on the same edge.
    assign accept_c = rst_n && req_i && ((state_q == IDLE) || done_c);

    assign accept_c_o = accept_c;
    assign done_c_o   = done_c;
    assign wait_o     = wait_q;
    assign valid_o    = valid_q;

    // Port FSM, latency counter and registered wait/valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= done_c;
            if (accept_c) begin
                state_q <= BUSY;
                cnt_q   <= '0;
                wait_q  <= (LATENCY > 1);
            end else if (done_c) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                wait_q  <= 1'b0;
            end else if (state_q == BUSY) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                // wait drops one edge before completion so a held request lands on it
                wait_q <= ((32'(cnt_q) + 32'd2) < LATENCY);
            end
        end
    end

endmodule

// File: rtl/mmu_seg.sv
// Dual-port (fetch + data) word-addressed MMU front end with null, special,
// main-memory and invalid regions, byte-enable writes and segfault reporting.
module mmu_seg
    import mmu_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned SPECIAL_WORDS = 16,
    parameter int unsigned MEM_BASE      = 32,
    parameter int unsigned MEM_WORDS     = 128,
    parameter int unsigned D_LATENCY     = 1,
    parameter int unsigned I_LATENCY     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic [DATA_W-1:0]   instr,
    output logic                instr_valid,
    output logic                wait_instr,
    output logic                instr_segv,
    input  logic                data_rd,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   data,
    output logic                data_valid,
    output logic                wait_data,
    output logic                data_segv
);

    localparam int unsigned MEM_IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned SP_IW  = (SPECIAL_WORDS > 1) ? $clog2(SPECIAL_WORDS) : 1;
    localparam int unsigned IDX_W  = (MEM_IW > SP_IW) ? MEM_IW : SP_IW;

    logic [DATA_W-1:0] mem_q  [MEM_WORDS];
    logic [DATA_W-1:0] spec_q [SPECIAL_WORDS];

    logic              d_accept_c, d_done_c;
    logic              i_accept_c, i_done_c;
    region_e           d_reg_c, i_reg_c;
    logic [IDX_W-1:0]  d_idx_c, i_idx_c;
    logic [DATA_W-1:0] d_old_c, d_merge_c;
    logic              d_wr_mem_c, d_wr_spec_c;

    region_e           d_region_q, i_region_q;
    logic [IDX_W-1:0]  d_idx_q, i_idx_q;
    logic [DATA_W-1:0] data_q, instr_q;
    logic              data_segv_q, instr_segv_q;

    mmu_port_ctrl #(.LATENCY(D_LATENCY)) u_dctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (data_rd | data_wr),
        .accept_c_o (d_accept_c),
        .done_c_o   (d_done_c),
        .wait_o     (wait_data),
        .valid_o    (data_valid)
    );

    mmu_port_ctrl #(.LATENCY(I_LATENCY)) u_ictrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (instr_req),
        .accept_c_o (i_accept_c),
        .done_c_o   (i_done_c),
        .wait_o     (wait_instr),
        .valid_o    (instr_valid)
    );

    // Decode of the addresses presented this cycle.
    assign d_reg_c = mmu_region(MAX_W'(data_addr), MAX_W'(SPECIAL_WORDS),
                                MAX_W'(MEM_BASE), MAX_W'(MEM_WORDS));
    assign i_reg_c = mmu_region(MAX_W'(instr_addr), MAX_W'(SPECIAL_WORDS),
                                MAX_W'(MEM_BASE), MAX_W'(MEM_WORDS));
    assign d_idx_c = IDX_W'(mmu_index(MAX_W'(data_addr), d_reg_c, MAX_W'(MEM_BASE)));
    assign i_idx_c = IDX_W'(mmu_index(MAX_W'(instr_addr), i_reg_c, MAX_W'(MEM_BASE)));

    // Write path: merge into the currently stored word at the accept edge.
    assign d_old_c     = (d_reg_c == REG_MEM) ? mem_q[MEM_IW'(d_idx_c)] : spec_q[SP_IW'(d_idx_c)];
    assign d_merge_c   = DATA_W'(byte_merge(MAX_W'(d_old_c), MAX_W'(data_in), MAX_STRB_W'(wstrb)));
    assign d_wr_mem_c  = d_accept_c && data_wr && (d_reg_c == REG_MEM);
    assign d_wr_spec_c = d_accept_c && data_wr && (d_reg_c == REG_SPECIAL);

    assign data       = data_q;
    assign data_segv  = data_segv_q;
    assign instr      = instr_q;
    assign instr_segv = instr_segv_q;

    // Main memory: not cleared by reset.
    always_ff @(posedge clk) begin
        if (d_wr_mem_c) mem_q[MEM_IW'(d_idx_c)] <= d_merge_c;
    end

    // Special registers: cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SPECIAL_WORDS); k++) spec_q[k] <= '0;
        end else if (d_wr_spec_c) begin
            spec_q[SP_IW'(d_idx_c)] <= d_merge_c;
        end
    end

    // Latch region and index at accept for the read issued at completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_region_q <= REG_NULL;
            d_idx_q    <= '0;
            i_region_q <= REG_NULL;
            i_idx_q    <= '0;
        end else begin
            if (d_accept_c) begin
                d_region_q <= d_reg_c;
                d_idx_q    <= d_idx_c;
            end
            if (i_accept_c) begin
                i_region_q <= i_reg_c;
                i_idx_q    <= i_idx_c;
            end
        end
    end

    // Data result: read after any write committed at accept, zero on fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            data_segv_q <= 1'b0;
        end else if (d_done_c) begin
            case (d_region_q)
                REG_MEM: begin
                    data_q      <= mem_q[MEM_IW'(d_idx_q)];
                    data_segv_q <= 1'b0;
                end
                REG_SPECIAL: begin
                    data_q      <= spec_q[SP_IW'(d_idx_q)];
                    data_segv_q <= 1'b0;
                end
                default: begin
                    data_q      <= '0;
                    data_segv_q <= 1'b1;
                end
            endcase
        end
    end

    // Fetch result: only main memory is executable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q      <= '0;
            instr_segv_q <= 1'b0;
        end else if (i_done_c) begin
            if (i_region_q == REG_MEM) begin
                instr_q      <= mem_q[MEM_IW'(i_idx_q)];
                instr_segv_q <= 1'b0;
            end else begin
                instr_q      <= '0;
                instr_segv_q <= 1'b1;
            end
        end
    end

endmodule
